// File: rtl/button_defs.sv
// Shared definitions for the button event arbiter: FSM encodings and default button count.
package button_defs;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting one past the last winner,
// using a doubled request vector so the wrap-around is a plain linear scan.
module rr_arbiter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned ID_WIDTH = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]    req,
  input  logic [ID_WIDTH-1:0] last,
  output logic                grant_valid,
  output logic [ID_WIDTH-1:0] grant_id
);

  logic [2*WIDTH-1:0] dbl;

  assign dbl = {req, req};

  always_comb begin
    logic [2*WIDTH-1:0] shifted;
    int unsigned        pos;
    grant_valid = 1'b0;
    grant_id    = '0;
    shifted     = '0;
    pos         = 0;
    // Offsets 1..WIDTH from last cover every button exactly once; first hit wins.
    for (int unsigned i = 1; i <= WIDTH; i++) begin
      pos     = i + 32'(last);
      shifted = dbl >> pos;
      if (!grant_valid && shifted[0]) begin
        grant_valid = 1'b1;
        grant_id    = ID_WIDTH'((pos >= WIDTH) ? (pos - WIDTH) : pos);
      end
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Turns debounced button levels into press events and serialises them round-robin
// onto a single valid/ready port, keeping per-button pending and sticky overflow flags.
module button_event_arbiter
  import button_defs::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned ID_WIDTH = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    debounced_signal,
  input  logic [WIDTH-1:0]    enable_mask,
  input  logic                clear_overflow,
  output logic                event_valid,
  input  logic                event_ready,
  output logic [ID_WIDTH-1:0] event_id,
  output logic [WIDTH-1:0]    pending,
  output logic [WIDTH-1:0]    overflow
);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    prev_q;
  logic [WIDTH-1:0]    pending_q, pending_d;
  logic [WIDTH-1:0]    overflow_q, overflow_d;
  logic [ID_WIDTH-1:0] event_id_q;
  logic [ID_WIDTH-1:0] last_grant_q;
  logic [WIDTH-1:0]    rise;
  logic [WIDTH-1:0]    grant_vec;
  logic                grant;
  logic                grant_valid;
  logic [ID_WIDTH-1:0] grant_id;

  assign rise = debounced_signal & ~prev_q & enable_mask;

  rr_arbiter #(
    .WIDTH    (WIDTH),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_arbiter (
    .req         (pending_q),
    .last        (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          grant   = 1'b1;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (event_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_vec  = grant ? (WIDTH'(1) << grant_id) : '0;
    // Mask clears, then a fresh rise beats a same-cycle grant clear.
    pending_d  = enable_mask & (rise | (pending_q & ~grant_vec));
    overflow_d = (overflow_q & ~{WIDTH{clear_overflow}}) | (rise & pending_q & ~grant_vec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      prev_q       <= '1;
      pending_q    <= '0;
      overflow_q   <= '0;
      event_id_q   <= '0;
      last_grant_q <= ID_WIDTH'(WIDTH - 1);
    end else begin
      state_q    <= state_d;
      prev_q     <= debounced_signal;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      if (grant) begin
        event_id_q   <= grant_id;
        last_grant_q <= grant_id;
      end
    end
  end

  assign event_valid = (state_q == ST_OFFER);
  assign event_id    = event_id_q;
  assign pending     = pending_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: each task drives one scenario and checks
// {valid, id, pending, overflow} cycle by cycle against hand-computed values.
module tb_button_event_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] debounced_signal;
  logic [3:0] enable_mask;
  logic       clear_overflow;
  logic       event_valid;
  logic       event_ready;
  logic [1:0] event_id;
  logic [3:0] pending;
  logic [3:0] overflow;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [10:0] exp;

  button_event_arbiter #(
    .WIDTH (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .debounced_signal (debounced_signal),
    .enable_mask      (enable_mask),
    .clear_overflow   (clear_overflow),
    .event_valid      (event_valid),
    .event_ready      (event_ready),
    .event_id         (event_id),
    .pending          (pending),
    .overflow         (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // event_id is only meaningful while an event is offered.
  function automatic logic [10:0] status();
    status = {event_valid, event_valid ? event_id : 2'd0, pending, overflow};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) tick();
    exp = {1'b0, 2'd0, 4'b0000, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL reset_state got=%b want=%b", status(), exp); end
    checks++;
    if (event_id !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d want=0", event_id); end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp = {1'b0, 2'd0, 4'b0000, 4'b0000}; checks++;
      if (status() !== exp) begin errors++; $display("FAIL held_no_event[%0d] got=%b want=%b", i, status(), exp); end
    end
    debounced_signal = 4'b0000;
    repeat (2) tick();
  endtask

  task automatic test_round_robin();
    event_ready = 1'b0;
    debounced_signal = 4'b1011;
    tick(); exp = {1'b0, 2'd0, 4'b1011, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL rr_pend got=%b want=%b", status(), exp); end
    tick(); exp = {1'b1, 2'd0, 4'b1010, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL rr_first got=%b want=%b", status(), exp); end
    event_ready = 1'b1;
    tick(); exp = {1'b0, 2'd0, 4'b1010, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL rr_gap1 got=%b want=%b", status(), exp); end
    event_ready = 1'b0;
    tick(); exp = {1'b1, 2'd1, 4'b1000, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL rr_second got=%b want=%b", status(), exp); end
    event_ready = 1'b1;
    tick(); exp = {1'b0, 2'd0, 4'b1000, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL rr_gap2 got=%b want=%b", status(), exp); end
    event_ready = 1'b0;
    tick(); exp = {1'b1, 2'd3, 4'b0000, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL rr_third got=%b want=%b", status(), exp); end
    event_ready = 1'b1;
    tick(); exp = {1'b0, 2'd0, 4'b0000, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL rr_done got=%b want=%b", status(), exp); end
    event_ready = 1'b0;
    debounced_signal = 4'b0000;
    tick();
  endtask

  task automatic test_wrap();
    event_ready = 1'b1;
    debounced_signal = 4'b0001;
    tick(); tick(); exp = {1'b1, 2'd0, 4'b0000, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL wrap_prime got=%b want=%b", status(), exp); end
    debounced_signal = 4'b0000;
    tick(); tick();
    debounced_signal = 4'b0011;
    tick(); exp = {1'b0, 2'd0, 4'b0011, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL wrap_pend got=%b want=%b", status(), exp); end
    tick(); exp = {1'b1, 2'd1, 4'b0001, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL wrap_first got=%b want=%b", status(), exp); end
    tick(); tick(); exp = {1'b1, 2'd0, 4'b0000, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL wrap_second got=%b want=%b", status(), exp); end
    debounced_signal = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_single();
    event_ready = 1'b1;
    debounced_signal = 4'b0100;
    tick(); exp = {1'b0, 2'd0, 4'b0100, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL single_n1 got=%b want=%b", status(), exp); end
    tick(); exp = {1'b1, 2'd2, 4'b0000, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL single_n2 got=%b want=%b", status(), exp); end
    tick(); exp = {1'b0, 2'd0, 4'b0000, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL single_n3 got=%b want=%b", status(), exp); end
    debounced_signal = 4'b0000;
    event_ready = 1'b0;
    tick();
  endtask

  task automatic test_stall_overflow();
    logic [3:0] pend_exp;
    logic [3:0] ovf_exp;
    event_ready = 1'b0;
    debounced_signal = 4'b0010;
    tick(); tick(); exp = {1'b1, 2'd1, 4'b0000, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL stall_offer got=%b want=%b", status(), exp); end
    for (int i = 0; i < 10; i++) begin
      tick();
      pend_exp = (i >= 3) ? 4'b0010 : 4'b0000;
      ovf_exp  = (i >= 5) ? 4'b0010 : 4'b0000;
      exp = {1'b1, 2'd1, pend_exp, ovf_exp}; checks++;
      if (status() !== exp) begin errors++; $display("FAIL stall[%0d] got=%b want=%b", i, status(), exp); end
      if (i == 1 || i == 3) debounced_signal = 4'b0000;
      if (i == 2 || i == 4) debounced_signal = 4'b0010;
    end
    debounced_signal = 4'b0000;
    tick();
    debounced_signal = 4'b0010;
    clear_overflow = 1'b1;
    tick(); exp = {1'b1, 2'd1, 4'b0010, 4'b0010}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL ovf_set_beats_clear got=%b want=%b", status(), exp); end
    tick(); exp = {1'b1, 2'd1, 4'b0010, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL ovf_clear got=%b want=%b", status(), exp); end
    clear_overflow = 1'b0;
    event_ready = 1'b1;
    tick(); exp = {1'b0, 2'd0, 4'b0010, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL stall_accept got=%b want=%b", status(), exp); end
    tick(); exp = {1'b1, 2'd1, 4'b0000, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL stall_reoffer got=%b want=%b", status(), exp); end
    tick();
    event_ready = 1'b0;
    debounced_signal = 4'b0000;
    tick();
  endtask

  task automatic test_mask();
    event_ready = 1'b0;
    debounced_signal = 4'b0001;
    tick(); tick(); exp = {1'b1, 2'd0, 4'b0000, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL mask_offer got=%b want=%b", status(), exp); end
    debounced_signal = 4'b1001;
    tick(); exp = {1'b1, 2'd0, 4'b1000, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL mask_pend3 got=%b want=%b", status(), exp); end
    enable_mask = 4'b0110;
    tick(); exp = {1'b1, 2'd0, 4'b0000, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL mask_clear got=%b want=%b", status(), exp); end
    debounced_signal = 4'b0001;
    tick();
    debounced_signal = 4'b1001;
    tick(); tick(); exp = {1'b1, 2'd0, 4'b0000, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL mask_ignore got=%b want=%b", status(), exp); end
    enable_mask = 4'b1111;
    event_ready = 1'b1;
    tick(); tick(); exp = {1'b0, 2'd0, 4'b0000, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL mask_drain got=%b want=%b", status(), exp); end
    event_ready = 1'b0;
    debounced_signal = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_offer();
    event_ready = 1'b0;
    debounced_signal = 4'b0100;
    tick(); tick();
    debounced_signal = 4'b0101;
    tick();
    debounced_signal = 4'b0100;
    tick();
    debounced_signal = 4'b0101;
    tick(); exp = {1'b1, 2'd2, 4'b0001, 4'b0001}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL pre_reset got=%b want=%b", status(), exp); end
    rst_n = 1'b0;
    #1;
    exp = {1'b0, 2'd0, 4'b0000, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL async_reset got=%b want=%b", status(), exp); end
    checks++;
    if (event_id !== 2'd0) begin errors++; $display("FAIL async_reset_id got=%0d want=0", event_id); end
    tick();
    debounced_signal = 4'b0000;
    rst_n = 1'b1;
    tick(); tick(); exp = {1'b0, 2'd0, 4'b0000, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL post_reset got=%b want=%b", status(), exp); end
    event_ready = 1'b1;
    debounced_signal = 4'b0101;
    tick(); tick(); exp = {1'b1, 2'd0, 4'b0100, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL post_reset_first got=%b want=%b", status(), exp); end
    tick(); tick(); exp = {1'b1, 2'd2, 4'b0000, 4'b0000}; checks++;
    if (status() !== exp) begin errors++; $display("FAIL post_reset_second got=%b want=%b", status(), exp); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n            = 1'b0;
    debounced_signal = 4'b1111;
    enable_mask      = 4'b1111;
    clear_overflow   = 1'b0;
    event_ready      = 1'b0;
    test_reset();
    test_round_robin();
    test_wrap();
    test_single();
    test_stall_overflow();
    test_mask();
    test_reset_mid_offer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
